// File: rtl/lot_pkg.sv
// Shared types for the parking-lot occupancy monitor.
package lot_pkg;

  // Per-lane sensor sequencing states.
  typedef enum logic [2:0] {
    StIdle,
    StInA,
    StInAb,
    StInB,
    StOutB,
    StOutAb,
    StOutA,
    StFault
  } lane_state_e;

  // Synchronised sensor code, written {a, b}.
  localparam logic [1:0] AbNone  = 2'b00;
  localparam logic [1:0] AbOnlyB = 2'b01;
  localparam logic [1:0] AbOnlyA = 2'b10;
  localparam logic [1:0] AbBoth  = 2'b11;

endpackage

// File: rtl/lot_lane_fsm.sv
// One sensor lane: 2-flop synchronisers, direction FSM and registered pulses.
module lot_lane_fsm
  import lot_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic a_i,
  input  logic b_i,
  output logic inc_o,
  output logic dec_o,
  output logic fault_o
);

  logic        a_meta_q, a_sync_q;
  logic        b_meta_q, b_sync_q;
  logic [1:0]  ab;
  lane_state_e state_q, state_d;
  logic        inc_q, inc_d;
  logic        dec_q, dec_d;
  logic        fault_q, fault_d;

  // Bring the asynchronous sensor levels into the clock domain.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_meta_q <= 1'b0;
      a_sync_q <= 1'b0;
      b_meta_q <= 1'b0;
      b_sync_q <= 1'b0;
    end else begin
      a_meta_q <= a_i;
      a_sync_q <= a_meta_q;
      b_meta_q <= b_i;
      b_sync_q <= b_meta_q;
    end
  end

  assign ab = {a_sync_q, b_sync_q};

  // Next-state decode; pulses only when a full sequence returns to idle.
  always_comb begin
    state_d = state_q;
    inc_d   = 1'b0;
    dec_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (ab == AbOnlyA)      state_d = StInA;
        else if (ab == AbOnlyB) state_d = StOutB;
        else if (ab == AbBoth)  state_d = StFault;
      end
      StInA: begin
        if (ab == AbBoth)       state_d = StInAb;
        else if (ab == AbNone)  state_d = StIdle;
        else if (ab == AbOnlyB) state_d = StFault;
      end
      StInAb: begin
        if (ab == AbOnlyB)      state_d = StInB;
        else if (ab == AbOnlyA) state_d = StInA;
        else if (ab == AbNone)  state_d = StFault;
      end
      StInB: begin
        if (ab == AbNone) begin
          state_d = StIdle;
          inc_d   = 1'b1;
        end else if (ab == AbBoth) begin
          state_d = StInAb;
        end else if (ab == AbOnlyA) begin
          state_d = StFault;
        end
      end
      StOutB: begin
        if (ab == AbBoth)       state_d = StOutAb;
        else if (ab == AbNone)  state_d = StIdle;
        else if (ab == AbOnlyA) state_d = StFault;
      end
      StOutAb: begin
        if (ab == AbOnlyA)      state_d = StOutA;
        else if (ab == AbOnlyB) state_d = StOutB;
        else if (ab == AbNone)  state_d = StFault;
      end
      StOutA: begin
        if (ab == AbNone) begin
          state_d = StIdle;
          dec_d   = 1'b1;
        end else if (ab == AbBoth) begin
          state_d = StOutAb;
        end else if (ab == AbOnlyB) begin
          state_d = StFault;
        end
      end
      StFault: begin
        if (ab == AbNone) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    fault_d = (state_d == StFault);
  end

  // State and output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      inc_q   <= 1'b0;
      dec_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      inc_q   <= inc_d;
      dec_q   <= dec_d;
      fault_q <= fault_d;
    end
  end

  assign inc_o   = inc_q;
  assign dec_o   = dec_q;
  assign fault_o = fault_q;

endmodule

// File: rtl/lot_monitor.sv
// Multi-lane parking-lot occupancy monitor with saturating counter.
module lot_monitor
  import lot_pkg::*;
#(
  parameter int unsigned LANES    = 2,
  parameter int unsigned CAPACITY = 255,
  parameter int unsigned CNT_W    = $clog2(CAPACITY + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LANES-1:0] a,
  input  logic [LANES-1:0] b,
  input  logic             clr_err,
  output logic [LANES-1:0] inc,
  output logic [LANES-1:0] dec,
  output logic [LANES-1:0] fault,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             err_ovf,
  output logic             err_unf
);

  // Signed width wide enough that count +/- all lanes never wraps.
  localparam int unsigned PcW = $clog2(LANES + 1);
  localparam int unsigned DW  = CNT_W + PcW + 1;
  localparam logic signed [DW-1:0] CapS = DW'(CAPACITY);
  localparam logic [CNT_W-1:0]     CapC = CNT_W'(CAPACITY);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lot_lane_fsm u_lane (
      .clk_i   (clk),
      .rst_i   (rst),
      .a_i     (a[i]),
      .b_i     (b[i]),
      .inc_o   (inc[i]),
      .dec_o   (dec[i]),
      .fault_o (fault[i])
    );
  end

  logic [CNT_W-1:0]     count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 err_ovf_q, err_ovf_d;
  logic                 err_unf_q, err_unf_d;
  logic signed [DW-1:0] sum;
  logic                 ovf_set, unf_set;

  // Net the lane pulses into the count, clamp, and flag saturation.
  always_comb begin
    sum = $signed({{(DW - CNT_W){1'b0}}, count_q});
    for (int unsigned i = 0; i < LANES; i++) begin
      sum = sum + $signed({{(DW - 1){1'b0}}, inc[i]}) - $signed({{(DW - 1){1'b0}}, dec[i]});
    end
    ovf_set = (sum > CapS);
    unf_set = sum[DW-1];
    if (ovf_set)      count_d = CapC;
    else if (unf_set) count_d = '0;
    else              count_d = sum[CNT_W-1:0];
    full_d    = (count_d == CapC);
    empty_d   = (count_d == '0);
    // Setting wins over a same-cycle clear.
    err_ovf_d = ovf_set | (err_ovf_q & ~clr_err);
    err_unf_d = unf_set | (err_unf_q & ~clr_err);
  end

  // Counter and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      count_q   <= count_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      err_ovf_q <= err_ovf_d;
      err_unf_q <= err_unf_d;
    end
  end

  assign count   = count_q;
  assign full    = full_q;
  assign empty   = empty_q;
  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;

endmodule

// File: tb/tb_lot_monitor.sv
// Scoreboard bench: two monitors (capacity 255 and 3) share one set of lane stimulus.
module tb_lot_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] a, b;
  logic       clr_err;

  logic [1:0] inc_a, dec_a, fault_a, inc_b, dec_b, fault_b;
  logic [7:0] count_a;
  logic [1:0] count_b;
  logic       full_a, empty_a, ovf_a, unf_a;
  logic       full_b, empty_b, ovf_b, unf_b;

  lot_monitor dut_a (
    .clk(clk), .rst(rst), .a(a), .b(b), .clr_err(clr_err),
    .inc(inc_a), .dec(dec_a), .fault(fault_a), .count(count_a),
    .full(full_a), .empty(empty_a), .err_ovf(ovf_a), .err_unf(unf_a)
  );

  lot_monitor #(.LANES(2), .CAPACITY(3)) dut_b (
    .clk(clk), .rst(rst), .a(a), .b(b), .clr_err(clr_err),
    .inc(inc_b), .dec(dec_b), .fault(fault_b), .count(count_b),
    .full(full_b), .empty(empty_b), .err_ovf(ovf_b), .err_unf(unf_b)
  );

  always #5 clk = ~clk;

  typedef logic [1:0] seq_t [4];
  typedef struct {
    logic [1:0] inc;
    logic [1:0] dec;
    int         cnt_a;
    int         cnt_b;
    bit         ovf_a, unf_a, ovf_b, unf_b;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  bit   pend;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_cnt_a, m_cnt_b;
  bit   m_ovf_a, m_unf_a, m_ovf_b, m_unf_b;

  seq_t seq_in   = '{2'b10, 2'b11, 2'b01, 2'b00};
  seq_t seq_out  = '{2'b01, 2'b11, 2'b10, 2'b00};
  seq_t seq_idle = '{2'b00, 2'b00, 2'b00, 2'b00};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input int cap, input int delta, inout int cnt, inout bit ovf,
                            inout bit unf);
    int s;
    s = cnt + delta;
    if (s > cap) begin
      cnt = cap;
      ovf = 1'b1;
    end else if (s < 0) begin
      cnt = 0;
      unf = 1'b1;
    end else begin
      cnt = s;
    end
  endtask

  task automatic push_exp(input logic [1:0] ei, input logic [1:0] ed);
    exp_t e;
    int   delta;
    delta = $countones(ei) - $countones(ed);
    model_step(255, delta, m_cnt_a, m_ovf_a, m_unf_a);
    model_step(3, delta, m_cnt_b, m_ovf_b, m_unf_b);
    e.inc = ei;  e.dec = ed;
    e.cnt_a = m_cnt_a;  e.cnt_b = m_cnt_b;
    e.ovf_a = m_ovf_a;  e.unf_a = m_unf_a;
    e.ovf_b = m_ovf_b;  e.unf_b = m_unf_b;
    exp_q.push_back(e);
  endtask

  task automatic set_lanes(input logic [1:0] c0, input logic [1:0] c1, input int hold);
    a = {c1[1], c0[1]};
    b = {c1[0], c0[0]};
    repeat (hold) @(negedge clk);
  endtask

  task automatic run_seq(input seq_t s0, input seq_t s1, input logic [1:0] ei,
                         input logic [1:0] ed);
    for (int i = 0; i < 4; i++) begin
      if (i == 3 && (ei | ed) != 2'b00) push_exp(ei, ed);
      set_lanes(s0[i], s1[i], 4);
    end
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_cnt_a"}, 32'(count_a), 0);
    check_eq({tag, "_cnt_b"}, 32'(count_b), 0);
    check_eq({tag, "_empty"}, {30'd0, empty_a, empty_b}, 32'h3);
    check_eq({tag, "_full"}, {30'd0, full_a, full_b}, 0);
    check_eq({tag, "_err"}, {28'd0, ovf_a, unf_a, ovf_b, unf_b}, 0);
    check_eq({tag, "_pulses"}, {24'd0, inc_a, dec_a, inc_b, dec_b}, 0);
    check_eq({tag, "_fault"}, {28'd0, fault_a, fault_b}, 0);
  endtask

  // Scoreboard: pop on each pulse, check the counter one cycle later.
  always @(negedge clk) begin
    if (rst) begin
      pend = 1'b0;
    end else begin
      if (pend) begin
        check_eq("count_a", 32'(count_a), 32'(cur.cnt_a));
        check_eq("count_b", 32'(count_b), 32'(cur.cnt_b));
        check_eq("full_empty_a", {30'd0, full_a, empty_a},
                 {30'd0, cur.cnt_a == 255, cur.cnt_a == 0});
        check_eq("full_empty_b", {30'd0, full_b, empty_b},
                 {30'd0, cur.cnt_b == 3, cur.cnt_b == 0});
        check_eq("err_a", {30'd0, ovf_a, unf_a}, {30'd0, cur.ovf_a, cur.unf_a});
        check_eq("err_b", {30'd0, ovf_b, unf_b}, {30'd0, cur.ovf_b, cur.unf_b});
        pend = 1'b0;
      end
      if ((inc_a | dec_a | inc_b | dec_b) != 2'b00) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_pulse", {24'd0, inc_a, dec_a, inc_b, dec_b}, 0);
        end else begin
          cur = exp_q.pop_front();
          check_eq("pulse_a", {28'd0, inc_a, dec_a}, {28'd0, cur.inc, cur.dec});
          check_eq("pulse_b", {28'd0, inc_b, dec_b}, {28'd0, cur.inc, cur.dec});
          pend = 1'b1;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;  a = 2'b00;  b = 2'b00;  clr_err = 1'b0;  pend = 1'b0;
    m_cnt_a = 0;  m_cnt_b = 0;
    m_ovf_a = 0;  m_unf_a = 0;  m_ovf_b = 0;  m_unf_b = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Entry on lane 0 with exact pulse timing.
    set_lanes(2'b10, 2'b00, 4);
    set_lanes(2'b11, 2'b00, 4);
    set_lanes(2'b01, 2'b00, 4);
    a = 2'b00;  b = 2'b00;
    push_exp(2'b01, 2'b00);
    @(posedge clk);
    @(posedge clk);  #1 check_eq("lat_early", 32'(inc_a), 0);
    @(posedge clk);  #1 check_eq("lat_k2", 32'(inc_a), 32'h1);
    @(posedge clk);  #1 check_eq("pulse_width", 32'(inc_a), 0);
    repeat (3) @(negedge clk);

    // Exit on lane 1 back to empty.
    run_seq(seq_idle, seq_out, 2'b00, 2'b10);
    check_eq("exit_empty", 32'(empty_a), 1);

    // Entry abort, then both sensors from idle.
    set_lanes(2'b10, 2'b00, 4);
    set_lanes(2'b00, 2'b00, 5);
    check_eq("abort_count", 32'(count_a), 0);
    set_lanes(2'b11, 2'b00, 4);
    check_eq("fault_set", {28'd0, fault_a, fault_b}, 32'h5);
    set_lanes(2'b00, 2'b00, 4);
    check_eq("fault_clr", {28'd0, fault_a, fault_b}, 0);

    // Saturate the small-capacity monitor.
    for (int i = 0; i < 4; i++) run_seq(seq_in, seq_idle, 2'b01, 2'b00);
    check_eq("sat_full_b", {30'd0, full_b, ovf_b}, 32'h3);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    m_ovf_a = 0;  m_unf_a = 0;  m_ovf_b = 0;  m_unf_b = 0;
    check_eq("clr_ovf_b", 32'(ovf_b), 0);
    check_eq("clr_cnt_b", 32'(count_b), 3);

    // Reach five, then net an entry and exit in the same cycle.
    run_seq(seq_in, seq_idle, 2'b01, 2'b00);
    run_seq(seq_in, seq_out, 2'b01, 2'b10);
    check_eq("net_cnt_a", 32'(count_a), 5);

    // Drain to underflow the small monitor.
    for (int i = 0; i < 4; i++) run_seq(seq_idle, seq_out, 2'b00, 2'b10);
    check_eq("unf_b", 32'(unf_b), 1);

    // Reset while lane 0 sits in the middle of an entry.
    set_lanes(2'b10, 2'b00, 4);
    set_lanes(2'b11, 2'b00, 4);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("mid_rst");
    exp_q.delete();
    m_cnt_a = 0;  m_cnt_b = 0;
    m_ovf_a = 0;  m_unf_a = 0;  m_ovf_b = 0;  m_unf_b = 0;
    @(negedge clk);
    set_lanes(2'b01, 2'b00, 2);
    rst = 1'b0;
    set_lanes(2'b01, 2'b00, 4);
    set_lanes(2'b00, 2'b00, 5);
    check_eq("post_rst_cnt", 32'(count_a), 0);
    run_seq(seq_in, seq_idle, 2'b01, 2'b00);
    check_eq("fresh_entry", 32'(count_a), 1);

    check_eq("sb_drain", 32'(exp_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
